// File: rtl/rr_mux_arbiter_8.sv
// rr_mux_arbiter_8
// Round-robin arbiter that owns the 3-bit select of a shared 8:1 mux.
// It grants the path to one requester at a time, rotates fairly and limits
// how long one owner keeps the path while others are waiting.
//
// Parameters:
//   MAX_HOLD  consecutive cycles an owner may keep the grant while another
//             requester waits (legal range 1..15)
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   req       request vector, req[i] = requester i wants the path
//   grant     registered one-hot grant, zero when idle
//   sel       mux select: index of the current or most recent owner
//   busy      high while a grant is active
//   hold_cnt  cycles the current owner has held the grant, minus 1
module rr_mux_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic [3:0] hold_cnt
);

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       sel_q,   sel_d;
  logic                   busy_q,  busy_d;
  logic [CNT_W-1:0]       hold_q,  hold_d;
  logic [IDX_W-1:0]       ptr_q,   ptr_d;

  // Candidates exclude the current owner; grant_q is zero when idle.
  logic [NUM_REQ-1:0]     cand;
  logic                   cand_found;
  logic [IDX_W-1:0]       cand_idx;
  logic                   owner_req;

  // First set candidate bit scanning ptr, ptr+1, ... with 3-bit wrap.
  // While granting, ptr equals owner+1, so this scan also serves handover.
  always_comb begin
    logic [IDX_W-1:0] idx;
    cand       = req & ~grant_q;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + IDX_W'(k);
      if (!cand_found && cand[idx]) begin
        cand_found = 1'b1;
        cand_idx   = idx;
      end
    end
  end

  assign owner_req = req[sel_q];

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cand_found) begin
          state_d = ST_GRANT;
          grant_d = NUM_REQ'(1) << cand_idx;
          sel_d   = cand_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
          ptr_d   = cand_idx + IDX_W'(1);
        end
      end

      ST_GRANT: begin
        if (!owner_req || (hold_q == HOLD_LAST && cand_found)) begin
          // Release or hold-limit preemption; release wins when both apply,
          // and both pick the same successor.
          if (cand_found) begin
            grant_d = NUM_REQ'(1) << cand_idx;
            sel_d   = cand_idx;
            hold_d  = '0;
            ptr_d   = cand_idx + IDX_W'(1);
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant    = grant_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Directed self-checking bench for rr_mux_arbiter_8 (MAX_HOLD = 4).
module tb_rr_mux_arbiter_8;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic [3:0] hold_cnt;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant    (grant),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                         input logic b, input logic [3:0] h);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".sel"}, 32'(sel), 32'(s));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".hold"}, 32'(hold_cnt), 32'(h));
  endtask

  initial begin
    logic [7:0] exp_g;
    reset = 1'b1;
    req   = 8'hFF;

    // Reset held two cycles with every request active.
    step();
    step();
    chk_all("reset", 8'h00, 3'd0, 1'b0, 4'd0);

    // Release reset: owner 0 one edge later, then 4-cycle rotation 0..7,0.
    reset = 1'b0;
    step();
    for (int k = 0; k < 36; k++) begin
      exp_g = 8'h01 << ((k / 4) % 8);
      chk_all($sformatf("rot%0d", k), exp_g, 3'((k / 4) % 8), 1'b1, 4'(k % 4));
      step();
    end
    chk_all("rot_next", 8'h02, 3'd1, 1'b1, 4'd0);

    // Release with nobody else waiting -> idle, sel keeps last owner.
    req = 8'h00;
    step();
    chk_all("idle1", 8'h00, 3'd1, 1'b0, 4'd0);

    // Single requester 5: hold count saturates at 3, no preemption.
    req = 8'h20;
    step();
    for (int k = 0; k < 10; k++) begin
      chk_all($sformatf("single%0d", k), 8'h20, 3'd5, 1'b1, 4'((k < 3) ? k : 3));
      if (k < 9) step();
    end
    req = 8'h00;
    step();
    chk_all("single_drop", 8'h00, 3'd5, 1'b0, 4'd0);

    // ptr = 6: owner 7 found first, then early release wraps to 0.
    req = 8'h80;
    step();
    chk_all("own7", 8'h80, 3'd7, 1'b1, 4'd0);
    req = 8'h81;
    step();
    step();
    chk_all("own7_held", 8'h80, 3'd7, 1'b1, 4'd2);
    req = 8'h01;
    step();
    chk_all("wrap0", 8'h01, 3'd0, 1'b1, 4'd0);

    // Release from 0 to 2 (ptr becomes 3), then idle.
    req = 8'h04;
    step();
    chk_all("own2", 8'h04, 3'd2, 1'b1, 4'd0);
    req = 8'h00;
    step();
    chk_all("idle2", 8'h00, 3'd2, 1'b0, 4'd0);

    // Fairness skip: ptr = 3, req = 06 -> scan wraps to 1; preempt to 2 after 4.
    req = 8'h06;
    step();
    chk_all("skip1", 8'h02, 3'd1, 1'b1, 4'd0);
    step();
    step();
    step();
    chk_all("skip_hold3", 8'h02, 3'd1, 1'b1, 4'd3);
    step();
    chk_all("skip_pre2", 8'h04, 3'd2, 1'b1, 4'd0);

    // Owner 4, reset mid-grant at hold_cnt = 2.
    req = 8'h10;
    step();
    step();
    step();
    chk_all("own4_h2", 8'h10, 3'd4, 1'b1, 4'd2);
    reset = 1'b1;
    step();
    chk_all("mid_reset", 8'h00, 3'd0, 1'b0, 4'd0);
    reset = 1'b0;
    step();
    chk_all("post_reset", 8'h10, 3'd4, 1'b1, 4'd0);

    // Pointer must return to 0: with req = 30, ptr 0 picks 4 (ptr 5 would pick 5).
    reset = 1'b1;
    step();
    chk_all("reset3", 8'h00, 3'd0, 1'b0, 4'd0);
    reset = 1'b0;
    req = 8'h30;
    step();
    chk_all("ptr_zero", 8'h10, 3'd4, 1'b1, 4'd0);

    // Simultaneous release and preempt: 4 reaches hold 3, drops, 5 takes over.
    step();
    step();
    step();
    chk_all("own4_h3", 8'h10, 3'd4, 1'b1, 4'd3);
    req = 8'h20;
    step();
    chk_all("rel_pre", 8'h20, 3'd5, 1'b1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
